// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: pointer-addressed register bank behind an I2C slave core, shared with local logic
module i2c_reg_ctrl #(
   parameter int          ADDR_W   = 3,
   parameter logic [7:0]  RST_REG0 = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_start,
   input  logic              bus_rw,
   input  logic              bus_stop,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_req,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              loc_req,
   input  logic              loc_we,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic [7:0]        loc_wdata,
   output logic              loc_gnt,
   output logic [7:0]        loc_rdata,
   output logic [7:0]        reg0_out,
   output logic              led_out
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [1:0] S_IDLE = 2'd0, S_PTR = 2'd1, S_WR = 2'd2, S_RD = 2'd3;
   logic [1:0]        state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [7:0]        regs [DEPTH];
   logic              bus_wr, bus_rd, loc_go;
   assign bus_wr = (state == S_WR) && rx_valid;
   assign bus_rd = (state == S_RD) && tx_req;
   // loc_gnt high means this request was just served; it must be re-sampled before another grant
   assign loc_go = loc_req && !bus_wr && !bus_rd && !loc_gnt;
   assign reg0_out = regs[0];
   assign led_out  = regs[0][0];
   // next state: START beats STOP; the first byte after a write START is the pointer
   always_comb begin
      state_nxt = bus_start ? (bus_rw ? S_RD : S_PTR) :
                  bus_stop ? S_IDLE :
                  (state == S_PTR && rx_valid) ? S_WR : state;
   end
   // pointer load from the first written byte, auto-increment on every data byte, wraps naturally
   always_comb begin
      ptr_nxt = (state == S_PTR && rx_valid) ? rx_data[ADDR_W-1:0] :
                (bus_wr || bus_rd) ? ptr + ADDR_W'(1) : ptr;
   end
   // state and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end
   // single-port bank: bus write has priority, a local write lands only on a free cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= (i == 0) ? RST_REG0 : 8'h00;
      end else if (bus_wr) begin
         regs[ptr] <= rx_data;
      end else if (loc_go && loc_we) begin
         regs[loc_addr] <= loc_wdata;
      end
   end
   // read data to the slave core; a request outside a read transfer gets the idle pattern
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_valid <= tx_req;
         if (tx_req) tx_data <= bus_rd ? regs[ptr] : 8'hFF;
      end
   end
   // local grant and the pre-access register value, returned for reads and writes alike
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loc_gnt   <= 1'b0;
         loc_rdata <= 8'h00;
      end else begin
         loc_gnt <= loc_go;
         if (loc_go) loc_rdata <= regs[loc_addr];
      end
   end
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: vector table, directed corner cases and a random run against a reference model
module tb_i2c_reg_ctrl;
   localparam int AW = 3;
   localparam int D = 8;
   localparam logic [7:0] R0 = 8'hA4;
   localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3;
   logic clk = 1'b0, rst_n = 1'b0;
   logic bus_start = 0, bus_rw = 0, bus_stop = 0, rx_valid = 0, tx_req = 0;
   logic [7:0] rx_data = 0;
   logic loc_req = 0, loc_we = 0;
   logic [AW-1:0] loc_addr = 0;
   logic [7:0] loc_wdata = 0;
   logic [7:0] tx_data, loc_rdata, reg0_out;
   logic tx_valid, loc_gnt, led_out;
   int n_chk = 0, n_fail = 0;

   i2c_reg_ctrl #(.ADDR_W(AW), .RST_REG0(R0)) dut (
      .clk(clk), .rst_n(rst_n), .bus_start(bus_start), .bus_rw(bus_rw), .bus_stop(bus_stop),
      .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid),
      .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .reg0_out(reg0_out), .led_out(led_out));

   always #5 clk = ~clk;

   typedef struct {
      logic st, rw, sp, rv;
      logic [7:0] rd;
      logic tr, etv;
      logic [7:0] etd, er0;
   } vec_t;
   vec_t tv[26];

   function automatic vec_t mk(logic st, logic rw, logic sp, logic rv, logic [7:0] rd, logic tr,
                               logic etv, logic [7:0] etd, logic [7:0] er0);
      vec_t v;
      v.st = st; v.rw = rw; v.sp = sp; v.rv = rv; v.rd = rd; v.tr = tr;
      v.etv = etv; v.etd = etd; v.er0 = er0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus(input logic st, input logic rw, input logic sp, input logic rv,
                      input logic [7:0] rd, input logic tr);
      bus_start = st; bus_rw = rw; bus_stop = sp; rx_valid = rv; rx_data = rd; tx_req = tr;
      @(negedge clk);
      bus_start = 0; bus_stop = 0; rx_valid = 0; tx_req = 0;
   endtask

   task automatic loc_xfer(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                           output logic [7:0] rd);
      logic got = 0;
      loc_req = 1; loc_we = we; loc_addr = a; loc_wdata = wd;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = loc_gnt;
      end
      chk("loc_grant_arrived", {7'd0, got}, 8'd1);
      rd = loc_rdata;
      loc_req = 0;
   endtask

   logic [7:0] mem [D];
   int mode, mptr;
   logic e_tv, e_gnt;
   logic [7:0] e_td, e_rd;

   initial begin
      logic [7:0] r;
      tv[0]  = mk(1,0,0,0,8'h00,0, 0,8'h00,R0);
      tv[1]  = mk(0,0,0,1,8'h02,0, 0,8'h00,R0);
      tv[2]  = mk(0,0,0,1,8'hAA,0, 0,8'h00,R0);
      tv[3]  = mk(0,0,0,1,8'h55,0, 0,8'h00,R0);
      tv[4]  = mk(0,0,1,0,8'h00,0, 0,8'h00,R0);
      tv[5]  = mk(0,0,0,0,8'h00,1, 1,8'hFF,R0);
      tv[6]  = mk(1,1,0,0,8'h00,0, 0,8'hFF,R0);
      tv[7]  = mk(0,0,0,0,8'h00,1, 1,8'h00,R0);
      tv[8]  = mk(1,0,0,0,8'h00,0, 0,8'h00,R0);
      tv[9]  = mk(0,0,0,1,8'h06,0, 0,8'h00,R0);
      tv[10] = mk(0,0,0,1,8'h66,0, 0,8'h00,R0);
      tv[11] = mk(0,0,0,1,8'h77,0, 0,8'h00,R0);
      tv[12] = mk(0,0,0,1,8'h01,0, 0,8'h00,8'h01);
      tv[13] = mk(1,1,0,0,8'h00,0, 0,8'h00,8'h01);
      tv[14] = mk(0,0,0,1,8'hEE,0, 0,8'h00,8'h01);
      tv[15] = mk(0,0,0,0,8'h00,1, 1,8'h00,8'h01);
      tv[16] = mk(0,0,0,0,8'h00,1, 1,8'hAA,8'h01);
      tv[17] = mk(0,0,0,0,8'h00,1, 1,8'h55,8'h01);
      tv[18] = mk(0,0,1,0,8'h00,0, 0,8'h55,8'h01);
      tv[19] = mk(1,0,0,0,8'h00,0, 0,8'h55,8'h01);
      tv[20] = mk(0,0,0,1,8'h06,0, 0,8'h55,8'h01);
      tv[21] = mk(1,1,0,0,8'h00,0, 0,8'h55,8'h01);
      tv[22] = mk(0,0,0,0,8'h00,1, 1,8'h66,8'h01);
      tv[23] = mk(0,0,0,0,8'h00,1, 1,8'h77,8'h01);
      tv[24] = mk(0,0,0,0,8'h00,1, 1,8'h01,8'h01);
      tv[25] = mk(0,0,1,0,8'h00,0, 0,8'h01,8'h01);

      @(negedge clk);
      chk("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_loc_gnt", {7'd0, loc_gnt}, 8'd0);
      chk("rst_loc_rdata", loc_rdata, 8'h00);
      chk("rst_reg0", reg0_out, R0);
      chk("rst_led", {7'd0, led_out}, {7'd0, R0[0]});
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 26; i++) begin
         bus(tv[i].st, tv[i].rw, tv[i].sp, tv[i].rv, tv[i].rd, tv[i].tr);
         chk($sformatf("vec%0d_tx_valid", i), {7'd0, tx_valid}, {7'd0, tv[i].etv});
         chk($sformatf("vec%0d_tx_data", i), tx_data, tv[i].etd);
         chk($sformatf("vec%0d_reg0", i), reg0_out, tv[i].er0);
         chk($sformatf("vec%0d_led", i), {7'd0, led_out}, {7'd0, tv[i].er0[0]});
         chk($sformatf("vec%0d_loc_gnt", i), {7'd0, loc_gnt}, 8'd0);
      end

      loc_xfer(1, 0, 8'h00, r);
      chk("led_loc_rdata", r, 8'h01);
      chk("led_off_reg0", reg0_out, 8'h00);
      chk("led_off", {7'd0, led_out}, 8'd0);
      @(negedge clk);
      chk("no_second_gnt", {7'd0, loc_gnt}, 8'd0);

      bus(1,0,0,0,8'h00,0);
      bus(0,0,0,1,8'h03,0);
      loc_req = 1; loc_we = 1; loc_addr = 3; loc_wdata = 8'h11;
      bus(0,0,0,1,8'h22,0);
      chk("conflict_bus_first", {7'd0, loc_gnt}, 8'd0);
      @(negedge clk);
      chk("conflict_gnt", {7'd0, loc_gnt}, 8'd1);
      chk("conflict_rdata", loc_rdata, 8'h22);
      loc_req = 0;
      bus(0,0,1,0,8'h00,0);
      loc_xfer(0, 3, 8'h00, r);
      chk("conflict_final_reg3", r, 8'h11);

      loc_xfer(1, 0, 8'h81, r);
      bus(1,0,0,0,8'h00,0);
      bus(0,0,0,1,8'h05,0);
      bus(0,0,0,1,8'h7E,0);
      loc_req = 1; loc_we = 0; loc_addr = 5; rx_valid = 1; rx_data = 8'h33;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_tx_valid", {7'd0, tx_valid}, 8'd0);
      chk("arst_tx_data", tx_data, 8'h00);
      chk("arst_loc_gnt", {7'd0, loc_gnt}, 8'd0);
      chk("arst_loc_rdata", loc_rdata, 8'h00);
      chk("arst_reg0", reg0_out, R0);
      loc_req = 0; rx_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("arst_no_gnt", {7'd0, loc_gnt}, 8'd0);
      loc_xfer(0, 5, 8'h00, r);
      chk("arst_reg5", r, 8'h00);
      bus(1,1,0,0,8'h00,0);
      bus(0,0,0,0,8'h00,1);
      chk("arst_ptr0_read", tx_data, R0);
      bus(0,0,1,0,8'h00,0);

      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < D; i++) mem[i] = (i == 0) ? R0 : 8'h00;
      mode = M_IDLE; mptr = 0; e_tv = 0; e_gnt = 0; e_td = 8'h00; e_rd = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         logic bacc, ldo;
         bus_start = ($urandom_range(0, 7) == 0);
         bus_rw = 1'($urandom_range(0, 1));
         bus_stop = ($urandom_range(0, 15) == 0);
         rx_valid = ($urandom_range(0, 2) == 0);
         rx_data = 8'($urandom);
         tx_req = ($urandom_range(0, 2) == 0);
         if (e_gnt && $urandom_range(0, 1) == 0) loc_req = 0;
         else if (!loc_req && $urandom_range(0, 3) == 0) begin
            loc_req = 1; loc_we = 1'($urandom_range(0, 1));
            loc_addr = AW'($urandom); loc_wdata = 8'($urandom);
         end
         bacc = (mode == M_WR && rx_valid) || (mode == M_RD && tx_req);
         e_tv = tx_req;
         if (tx_req) e_td = (mode == M_RD) ? mem[mptr] : 8'hFF;
         ldo = loc_req && !bacc && !e_gnt;
         if (ldo) begin
            e_rd = mem[loc_addr];
            if (loc_we) mem[loc_addr] = loc_wdata;
         end
         e_gnt = ldo;
         if (mode == M_WR && rx_valid) begin
            mem[mptr] = rx_data;
            mptr = (mptr + 1) % D;
         end
         if (mode == M_RD && tx_req) mptr = (mptr + 1) % D;
         if (mode == M_PTR && rx_valid) mptr = rx_data % D;
         mode = bus_start ? (bus_rw ? M_RD : M_PTR) : bus_stop ? M_IDLE :
                (mode == M_PTR && rx_valid) ? M_WR : mode;
         @(negedge clk);
         chk("rnd_tx_valid", {7'd0, tx_valid}, {7'd0, e_tv});
         chk("rnd_tx_data", tx_data, e_td);
         chk("rnd_loc_gnt", {7'd0, loc_gnt}, {7'd0, e_gnt});
         chk("rnd_loc_rdata", loc_rdata, e_rd);
         chk("rnd_reg0", reg0_out, mem[0]);
         chk("rnd_led", {7'd0, led_out}, {7'd0, mem[0][0]});
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
- Register-bank controller behind the byte-level I2C slave core.
- Turns START/STOP/byte events from the slave core into pointer-addressed register reads and writes. Supports EEPROM-style pointer auto-increment.
- Shares the single-port bank with local FPGA logic through a request/grant port.
- Register 0 bit 0 drives the board LED.

Parameters:
- ADDR_W, 3, register index width; DEPTH = 2**ADDR_W registers.
- RST_REG0, 8'h00, reset value of register 0; all other registers reset to 8'h00.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_start  in  1  one-cycle pulse: START or repeated START with own address matched.
- bus_rw  in  1  direction, valid with bus_start; 1 = master read.
- bus_stop  in  1  one-cycle pulse: STOP seen.
- rx_valid  in  1  one-cycle pulse: byte received from master.
- rx_data  in  8  received byte, valid with rx_valid.
- tx_req  in  1  one-cycle pulse: slave core needs next byte to send.
- tx_data  out  8  byte to send.
- tx_valid  out  1  one-cycle pulse, tx_data valid.
- loc_req  in  1  local access request, held high until loc_gnt.
- loc_we  in  1  1 = write, 0 = read; held with loc_req.
- loc_addr  in  ADDR_W  local register index.
- loc_wdata  in  8  local write data.
- loc_gnt  out  1  one-cycle pulse, local access done.
- loc_rdata  out  8  local read data, valid with loc_gnt.
- reg0_out  out  8  live copy of register 0.
- led_out  out  1  register 0 bit 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, registers cleared, reg0=RST_REG0.
  - tx_data=8'h00, tx_valid=0, loc_gnt=0, loc_rdata=8'h00.
- States: IDLE, PTR (await pointer byte), WR (data bytes), RD (serving reads).
- Transitions:
  - bus_start from any state: bus_rw=0 -> PTR; bus_rw=1 -> RD.
  - bus_stop from any state -> IDLE. If bus_stop and bus_start arrive in the same cycle, bus_start wins.
  - PTR + rx_valid: ptr <= rx_data[ADDR_W-1:0] (upper bits ignored) -> WR.
- Writes and reads:
  - WR + rx_valid: reg[ptr] <= rx_data; ptr <= ptr+1.
  - RD + tx_req: next cycle tx_data=reg[ptr], tx_valid=1; ptr <= ptr+1.
  - A read with no preceding pointer write uses the retained ptr (current-address read).
  - Repeated START keeps ptr.
- Pointer wraps modulo DEPTH: DEPTH-1 -> 0.
- Ignored events:
  - rx_valid in IDLE or RD is ignored.
  - tx_req outside RD returns tx_data=8'hFF with tx_valid=1, ptr unchanged.
- Bank port and arbitration:
  - One bank access per cycle.
  - A bus access cycle is WR+rx_valid or RD+tx_req; it always has priority.
  - When loc_req=1 and the cycle is not a bus access cycle, the local access executes that cycle.
  - loc_gnt pulses the following cycle. loc_rdata = register value at the access cycle, for both reads and writes.
  - loc_gnt never pulses twice for one request. The next grant for the same request requires loc_req to be sampled again after loc_gnt.
  - Same-address conflict: the bus write lands first and the deferred local write lands later, so the local value wins.
- Outputs:
  - reg0_out and led_out are registered straight from register 0 and update the cycle after the write.
  - tx_valid and loc_gnt are single-cycle pulses.
- Reset mid-transaction aborts everything: state IDLE, pending local request not granted.

Test Plan:
1. Bus write: start(rw=0), rx 0x02, 0xAA, 0x55, stop -> reg2=0xAA, reg3=0x55, ptr=4, state IDLE.
2. Pointer then read: start(rw=0), rx 0x06, start(rw=1), tx_req x3 -> tx_data 0x06-reg, 0x07-reg, then reg0 (wrap). Each tx_valid arrives 1 cycle after its tx_req.
3. LED: bus write 0x01 to reg0 -> led_out=1 one cycle after rx_valid. Local write reg0=0x00 -> led_out=0.
4. Conflict: loc_req write reg3=0x11 asserted in the same cycle as bus rx_valid writing reg3=0x22:
   - bus write happens first; loc_gnt one cycle after the next free cycle.
   - final reg3=0x11, loc_rdata=0x22.
5. Stray events: tx_req in IDLE -> tx_data 0xFF, tx_valid=1, ptr unchanged. rx_valid in RD -> no register change.
6. Async reset asserted in WR after writing reg5=0x7E -> all outputs at reset values immediately, reg5=0x00, ptr=0, no loc_gnt.
